// File: rtl/alu_pipe_if.sv
// Operand-issue / result-writeback handshake bundle for alu_pipe.
// The issuing side uses master; the ALU uses slave.
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [4:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] p;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, x, y, opcode, out_ready,
        input  in_ready, out_valid, p, overflow, illegal
    );

    modport slave (
        input  in_valid, x, y, opcode, out_ready,
        output in_ready, out_valid, p, overflow, illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 holds operands, S2 holds the registered result.
// Valid/ready on both sides, sticky overflow and a delivered-result counter.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_pipe_if.slave        bus,
    input  logic             sticky_clr,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] op_count
);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_x_reg;
    logic [WIDTH-1:0] s1_y_reg;
    logic [4:0]       s1_op_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] p_reg;
    logic             overflow_reg;
    logic             illegal_reg;
    logic             ovf_sticky_reg;
    logic [CNT_W-1:0] op_count_reg;

    logic s2_adv;
    logic in_ready;
    logic in_fire;
    logic out_fire;

    assign s2_adv   = !out_valid_reg || bus.out_ready;
    assign in_ready = !s1_valid_reg || s2_adv;
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid_reg && bus.out_ready;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] diff_w;
    logic [WIDTH-1:0] shl_w;
    logic [WIDTH-1:0] shr_w;
    logic [WIDTH-1:0] sar_w;
    logic [WIDTH-1:0] sal_back_w;
    logic             x_sign;
    logic             y_sign;
    logic             lt_s;
    logic             eq_w;

    assign sum_w  = {1'b0, s1_x_reg} + {1'b0, s1_y_reg};
    assign diff_w = s1_x_reg - s1_y_reg;
    // Shift amounts >= WIDTH fall out naturally: zeros for <<, >>; sign fill for >>>.
    assign shl_w      = s1_x_reg << s1_y_reg;
    assign shr_w      = s1_x_reg >> s1_y_reg;
    assign sar_w      = $unsigned($signed(s1_x_reg) >>> s1_y_reg);
    assign sal_back_w = $unsigned($signed(shl_w) >>> s1_y_reg);
    assign x_sign     = s1_x_reg[WIDTH-1];
    assign y_sign     = s1_y_reg[WIDTH-1];
    assign lt_s       = $signed(s1_x_reg) < $signed(s1_y_reg);
    assign eq_w       = s1_x_reg == s1_y_reg;

    logic [WIDTH-1:0] p_next;
    logic             overflow_next;
    logic             illegal_next;

    always_comb begin
        p_next        = '0;
        overflow_next = 1'b0;
        illegal_next  = 1'b0;
        case (s1_op_reg)
            5'b00000: begin
                p_next        = sum_w[WIDTH-1:0];
                overflow_next = (x_sign == y_sign) && (sum_w[WIDTH-1] != x_sign);
            end
            5'b00001: begin
                p_next        = sum_w[WIDTH-1:0];
                overflow_next = sum_w[WIDTH];
            end
            5'b00010: begin
                p_next        = diff_w;
                overflow_next = (x_sign != y_sign) && (diff_w[WIDTH-1] != x_sign);
            end
            5'b00011: begin
                p_next        = diff_w;
                overflow_next = s1_x_reg < s1_y_reg;
            end
            5'b00100: begin
                p_next        = s1_x_reg + WIDTH'(1);
                overflow_next = s1_x_reg == MAX_POS;
            end
            5'b00101: begin
                p_next        = s1_x_reg - WIDTH'(1);
                overflow_next = s1_x_reg == MIN_NEG;
            end
            5'b01000: p_next = s1_x_reg & s1_y_reg;
            5'b01001: p_next = s1_x_reg | s1_y_reg;
            5'b01010: p_next = s1_x_reg ^ s1_y_reg;
            5'b01100: p_next = ~s1_x_reg;
            5'b10000: p_next = shl_w;
            5'b10001: p_next = shr_w;
            5'b10010: begin
                p_next        = shl_w;
                overflow_next = sal_back_w != s1_x_reg;
            end
            5'b10011: p_next = sar_w;
            5'b11000: p_next[0] = lt_s || eq_w;
            5'b11001: p_next[0] = lt_s;
            5'b11010: p_next[0] = !lt_s;
            5'b11011: p_next[0] = !lt_s && !eq_w;
            5'b11100: p_next[0] = eq_w;
            5'b11101: p_next[0] = !eq_w;
            default:  illegal_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_x_reg       <= '0;
            s1_y_reg       <= '0;
            s1_op_reg      <= '0;
            out_valid_reg  <= 1'b0;
            p_reg          <= '0;
            overflow_reg   <= 1'b0;
            illegal_reg    <= 1'b0;
            ovf_sticky_reg <= 1'b0;
            op_count_reg   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= bus.in_valid;
            end
            if (in_fire) begin
                s1_x_reg  <= bus.x;
                s1_y_reg  <= bus.y;
                s1_op_reg <= bus.opcode;
            end
            // Result registers only move when S2 frees up, so a stalled result stays put.
            if (s2_adv) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    p_reg        <= p_next;
                    overflow_reg <= overflow_next;
                    illegal_reg  <= illegal_next;
                end
            end
            if (out_fire && overflow_reg) begin
                ovf_sticky_reg <= 1'b1;
            end else if (sticky_clr) begin
                ovf_sticky_reg <= 1'b0;
            end
            if (out_fire) begin
                op_count_reg <= op_count_reg + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.p         = p_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.illegal   = illegal_reg;
    assign ovf_sticky    = ovf_sticky_reg;
    assign op_count      = op_count_reg;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=16): directed vectors, backpressure, sticky status,
// randomized traffic against an arithmetic reference model, and async reset.
module tb_alu_pipe;
    localparam int WIDTH = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sticky_clr = 1'b0;
    logic             ovf_sticky;
    logic [CNT_W-1:0] op_count;

    int n_total   = 0;
    int n_pass    = 0;
    int exp_count = 0;

    alu_pipe_if #(.WIDTH(WIDTH)) bus ();

    alu_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .sticky_clr (sticky_clr),
        .ovf_sticky (ovf_sticky),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  op;
        logic [15:0] p;
        logic        o;
        logic        i;
    } vec_t;

    vec_t vecs [20] = '{
        {16'h4006, 16'h4004, 5'b00000, 16'h800A, 1'b1, 1'b0},
        {16'h0006, 16'h0004, 5'b00000, 16'h000A, 1'b0, 1'b0},
        {16'h7FFF, 16'h0000, 5'b00100, 16'h8000, 1'b1, 1'b0},
        {16'h8000, 16'h0000, 5'b00101, 16'h7FFF, 1'b1, 1'b0},
        {16'hCC8E, 16'h0005, 5'b10011, 16'hFE64, 1'b0, 1'b0},
        {16'hCC8E, 16'h0005, 5'b10001, 16'h0664, 1'b0, 1'b0},
        {16'hCC8E, 16'h0014, 5'b10001, 16'h0000, 1'b0, 1'b0},
        {16'hCC8E, 16'h0014, 5'b10011, 16'hFFFF, 1'b0, 1'b0},
        {16'hCC8E, 16'h0014, 5'b10000, 16'h0000, 1'b0, 1'b0},
        {16'h7FFF, 16'h8089, 5'b11000, 16'h0000, 1'b0, 1'b0},
        {16'h8089, 16'h8089, 5'b11100, 16'h0001, 1'b0, 1'b0},
        {16'h1234, 16'h5678, 5'b00110, 16'h0000, 1'b0, 1'b1},
        {16'hFFFF, 16'h0001, 5'b00001, 16'h0000, 1'b1, 1'b0},
        {16'h0003, 16'h0005, 5'b00011, 16'hFFFE, 1'b1, 1'b0},
        {16'h4000, 16'h0001, 5'b10010, 16'h8000, 1'b1, 1'b0},
        {16'h0001, 16'h0014, 5'b10010, 16'h0000, 1'b1, 1'b0},
        {16'hF0F0, 16'hFF00, 5'b01010, 16'h0FF0, 1'b0, 1'b0},
        {16'h8000, 16'h0001, 5'b00010, 16'h7FFF, 1'b1, 1'b0},
        {16'h00FF, 16'h0000, 5'b01100, 16'hFF00, 1'b0, 1'b0},
        {16'h8000, 16'h7FFF, 5'b11001, 16'h0001, 1'b0, 1'b0}
    };

    // Reference model: integer arithmetic with range checks; returns {p, overflow, illegal}.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [4:0] op);
        int          sa;
        int          sb;
        int          ua;
        int          ub;
        int          r;
        longint      v;
        logic [15:0] pr;
        logic        o;
        logic        il;
        sa = $signed(a);
        sb = $signed(b);
        ua = int'(a);
        ub = int'(b);
        pr = '0;
        o  = 1'b0;
        il = 1'b0;
        case (op)
            5'b00000: begin r = sa + sb; pr = r[15:0]; o = (r > 32767) || (r < -32768); end
            5'b00001: begin r = ua + ub; pr = r[15:0]; o = r > 65535; end
            5'b00010: begin r = sa - sb; pr = r[15:0]; o = (r > 32767) || (r < -32768); end
            5'b00011: begin r = ua - ub; pr = r[15:0]; o = ua < ub; end
            5'b00100: begin r = sa + 1; pr = r[15:0]; o = sa == 32767; end
            5'b00101: begin r = sa - 1; pr = r[15:0]; o = sa == -32768; end
            5'b01000: pr = a & b;
            5'b01001: pr = a | b;
            5'b01010: pr = a ^ b;
            5'b01100: pr = ~a;
            5'b10000: begin if (ub < 16) begin r = ua << ub; pr = r[15:0]; end end
            5'b10001: begin if (ub < 16) begin r = ua >> ub; pr = r[15:0]; end end
            5'b10010: begin
                if (ub >= 16) begin
                    o = a != 16'h0;
                end else begin
                    v  = longint'(sa) * (longint'(1) << ub);
                    pr = v[15:0];
                    o  = (v > 32767) || (v < -32768);
                end
            end
            5'b10011: begin
                r  = (ub >= 16) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
                pr = r[15:0];
            end
            5'b11000: pr = 16'(sa <= sb);
            5'b11001: pr = 16'(sa < sb);
            5'b11010: pr = 16'(sa >= sb);
            5'b11011: pr = 16'(sa > sb);
            5'b11100: pr = 16'(sa == sb);
            5'b11101: pr = 16'(sa != sb);
            default:  il = 1'b1;
        endcase
        return {pr, o, il};
    endfunction

    // Single beat with out_ready=1; lat counts edges from presentation to out_valid.
    task automatic issue_one(input logic [15:0] a, input logic [15:0] b, input logic [4:0] op,
                             input logic clr, output logic [17:0] res, output int lat);
        @(negedge clk);
        bus.x         = a;
        bus.y         = b;
        bus.opcode    = op;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res        = {bus.p, bus.overflow, bus.illegal};
        sticky_clr = clr;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        exp_count++;
        $display("tx op=%b x=%h y=%h -> p=%h ovf=%b ill=%b lat=%0d",
                 op, a, b, res[17:2], res[1], res[0], lat);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.opcode    = '0;
        bus.out_ready = 1'b0;
        sticky_clr    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        exp_count = 0;
        @(negedge clk);
        n_total++;
        if ({bus.out_valid, bus.p, bus.overflow, bus.illegal} !== 19'h0)
            $display("FAIL reset_outputs got=%h exp=0",
                     {bus.out_valid, bus.p, bus.overflow, bus.illegal});
        else n_pass++;
        n_total++;
        if ({ovf_sticky, op_count} !== 17'h0)
            $display("FAIL reset_status got=%h exp=0", {ovf_sticky, op_count});
        else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [17:0] res;
        logic [17:0] want;
        int          lat;
        for (int i = 0; i < 20; i++) begin
            issue_one(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, res, lat);
            want = {vecs[i].p, vecs[i].o, vecs[i].i};
            n_total++;
            if (res !== want) $display("FAIL directed_%0d got=%h exp=%h", i, res, want);
            else n_pass++;
            n_total++;
            if (lat != 2) $display("FAIL latency_%0d got=%0d exp=2", i, lat);
            else n_pass++;
        end
        n_total++;
        if (op_count !== 16'(exp_count))
            $display("FAIL directed_count got=%0d exp=%0d", op_count, exp_count);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [15:0] a [3];
        logic [15:0] b [3];
        logic [4:0]  o [3];
        logic [17:0] want [3];
        logic [17:0] got [$];
        logic        accepted;
        for (int i = 0; i < 3; i++) begin
            a[i]    = 16'($urandom);
            b[i]    = 16'($urandom_range(0, 20));
            o[i]    = 5'($urandom_range(0, 31));
            want[i] = model(a[i], b[i], o[i]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.x         = a[i];
            bus.y         = b[i];
            bus.opcode    = o[i];
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b0;
            #1;
            n_total++;
            if (bus.in_ready !== (i < 2 ? 1'b1 : 1'b0))
                $display("FAIL bp_in_ready_%0d got=%b exp=%b", i, bus.in_ready, i < 2);
            else n_pass++;
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            n_total++;
            if ({bus.in_ready, bus.out_valid, bus.p, bus.overflow, bus.illegal} !== {2'b01, want[0]})
                $display("FAIL bp_stall got=%h exp=%h",
                         {bus.in_ready, bus.out_valid, bus.p, bus.overflow, bus.illegal},
                         {2'b01, want[0]});
            else n_pass++;
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_refill got=%b exp=1", bus.in_ready);
        else n_pass++;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid) got.push_back({bus.p, bus.overflow, bus.illegal});
            accepted = bus.in_valid && bus.in_ready;
            @(posedge clk);
            @(negedge clk);
            if (accepted) bus.in_valid = 1'b0;
            #1;
            if (got.size() == 3) break;
        end
        exp_count += 3;
        n_total++;
        if (got.size() != 3) $display("FAIL bp_count got=%0d exp=3", got.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            $display("tx bp #%0d op=%b x=%h y=%h -> %h", i, o[i], a[i], b[i], got[i]);
            n_total++;
            if (got[i] !== want[i]) $display("FAIL bp_order_%0d got=%h exp=%h", i, got[i], want[i]);
            else n_pass++;
        end
        n_total++;
        if (op_count !== 16'(exp_count))
            $display("FAIL bp_op_count got=%0d exp=%0d", op_count, exp_count);
        else n_pass++;
    endtask

    task automatic test_sticky();
        logic [17:0] res;
        int          lat;
        @(negedge clk);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        n_total++;
        if (ovf_sticky !== 1'b0) $display("FAIL sticky_clear0 got=%b exp=0", ovf_sticky);
        else n_pass++;
        issue_one(16'h7FFF, 16'h0000, 5'b00100, 1'b0, res, lat);
        n_total++;
        if (ovf_sticky !== 1'b1) $display("FAIL sticky_set got=%b exp=1", ovf_sticky);
        else n_pass++;
        issue_one(16'h0001, 16'h0001, 5'b00000, 1'b0, res, lat);
        n_total++;
        if (ovf_sticky !== 1'b1) $display("FAIL sticky_hold got=%b exp=1", ovf_sticky);
        else n_pass++;
        issue_one(16'h8000, 16'h0000, 5'b00101, 1'b1, res, lat);
        n_total++;
        if (ovf_sticky !== 1'b1) $display("FAIL sticky_set_wins got=%b exp=1", ovf_sticky);
        else n_pass++;
        @(negedge clk);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        n_total++;
        if (ovf_sticky !== 1'b0) $display("FAIL sticky_clear got=%b exp=0", ovf_sticky);
        else n_pass++;
        issue_one(16'h0002, 16'h0003, 5'b00001, 1'b0, res, lat);
        n_total++;
        if (ovf_sticky !== 1'b0) $display("FAIL sticky_stay0 got=%b exp=0", ovf_sticky);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [17:0] q [$];
        logic [17:0] want;
        logic [17:0] cur;
        logic [17:0] prev;
        logic        prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.in_valid  = ($urandom % 4) != 0;
            bus.x         = ($urandom % 5 == 0) ? 16'h7FFF : 16'($urandom);
            bus.y         = ($urandom % 3 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            bus.opcode    = 5'($urandom_range(0, 31));
            bus.out_ready = (c < 100) ? 1'b1 : (($urandom % 3) != 0);
            #1;
            cur = {bus.p, bus.overflow, bus.illegal};
            if (bus.out_ready || !bus.out_valid) begin
                n_total++;
                if (bus.in_ready !== 1'b1) $display("FAIL rnd_in_ready c=%0d got=%b exp=1", c, bus.in_ready);
                else n_pass++;
            end
            if (prev_stall) begin
                n_total++;
                if ({bus.out_valid, cur} !== {1'b1, prev})
                    $display("FAIL rnd_hold c=%0d got=%h exp=%h", c, {bus.out_valid, cur}, {1'b1, prev});
                else n_pass++;
            end
            if (bus.out_valid && bus.out_ready) begin
                want = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
                exp_count++;
                $display("tx rnd c=%0d -> p=%h ovf=%b ill=%b", c, bus.p, bus.overflow, bus.illegal);
                n_total++;
                if (cur !== want) $display("FAIL rnd_result c=%0d got=%h exp=%h", c, cur, want);
                else n_pass++;
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.x, bus.y, bus.opcode));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev       = cur;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            #1;
            if (bus.out_valid) begin
                want = q.pop_front();
                exp_count++;
                n_total++;
                if ({bus.p, bus.overflow, bus.illegal} !== want)
                    $display("FAIL rnd_drain got=%h exp=%h", {bus.p, bus.overflow, bus.illegal}, want);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_total++;
        if (q.size() != 0) $display("FAIL rnd_lost got=%0d exp=0", q.size());
        else n_pass++;
        n_total++;
        if (op_count !== 16'(exp_count))
            $display("FAIL rnd_op_count got=%0d exp=%0d", op_count, exp_count);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [17:0] res;
        int          lat;
        @(negedge clk);
        bus.x         = 16'h7FFF;
        bus.y         = 16'h0000;
        bus.opcode    = 5'b00100;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.x         = 16'h1111;
        bus.opcode    = 5'b01100;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.out_valid, bus.p, bus.overflow, bus.illegal, ovf_sticky, op_count} !== 36'h0)
            $display("FAIL areset_outputs got=%h exp=0",
                     {bus.out_valid, bus.p, bus.overflow, bus.illegal, ovf_sticky, op_count});
        else n_pass++;
        repeat (2) @(negedge clk);
        #2;
        rst_n         = 1'b1;
        exp_count     = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_total++;
            if ({bus.out_valid, bus.in_ready} !== 2'b01)
                $display("FAIL areset_spurious c=%0d got=%b exp=01", c, {bus.out_valid, bus.in_ready});
            else n_pass++;
        end
        n_total++;
        if (op_count !== 16'h0) $display("FAIL areset_count got=%0d exp=0", op_count);
        else n_pass++;
        issue_one(16'h4006, 16'h4004, 5'b00000, 1'b0, res, lat);
        n_total++;
        if ({res, op_count} !== {16'h800A, 2'b10, 16'h0001})
            $display("FAIL areset_after got=%h exp=%h", {res, op_count}, {16'h800A, 2'b10, 16'h0001});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_sticky();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
